// File: rtl/bram_arbiter_pkg.sv
// rtl/bram_arbiter_pkg.sv - shared widths, owner ids and read-tag type for the BRAM arbiter
package bram_arbiter_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    // The read-tag pipeline only models the two latencies the BRAM macro offers
    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// rtl/bram_arbiter_if.sv - bundle of both master ports and the shared BRAM port
interface bram_arbiter_if
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_lock;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus the BRAM instance
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/bram_arbiter_rd_tag_pipe.sv
// rtl/bram_arbiter_rd_tag_pipe.sv - RD_LAT-deep shift register of {valid, owner} read tags
module rd_tag_pipe
    import bram_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [RD_LAT-1:0] pipe_q;
    rd_tag_t [RD_LAT-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_in;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Clearing on reset drops reads in flight so they never raise rvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin two-master arbiter with lock for a single-port data BRAM
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    bram_arbiter_if.slave bus
);

    if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_check
        $error("bram_arbiter: RD_LAT must be 1 or 2");
    end

    owner_e            last_q;
    owner_e            last_d;
    logic              locked_q;
    logic              locked_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;

    logic              gnt_any;
    owner_e            gnt_id;
    logic              own_req;
    logic              own_lock;
    logic              sel_we;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    assign own_req  = (last_q == M1) ? bus.m1_req  : bus.m0_req;
    assign own_lock = (last_q == M1) ? bus.m1_lock : bus.m0_lock;

    // While locked the owner keeps the port even when idle; otherwise the
    // master that did not win last time takes a conflict.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = M0;
        if (!rst) begin
            if (locked_q) begin
                gnt_any = own_req;
                gnt_id  = last_q;
            end else if (bus.m0_req && bus.m1_req) begin
                gnt_any = 1'b1;
                gnt_id  = (last_q == M0) ? M1 : M0;
            end else if (bus.m0_req) begin
                gnt_any = 1'b1;
                gnt_id  = M0;
            end else if (bus.m1_req) begin
                gnt_any = 1'b1;
                gnt_id  = M1;
            end
        end
    end

    always_comb begin
        sel_we    = bus.m0_we;
        sel_lock  = bus.m0_lock;
        sel_addr  = bus.m0_addr;
        sel_wdata = bus.m0_wdata;
        if (gnt_id == M1) begin
            sel_we    = bus.m1_we;
            sel_lock  = bus.m1_lock;
            sel_addr  = bus.m1_addr;
            sel_wdata = bus.m1_wdata;
        end
    end

    always_comb begin
        last_d   = last_q;
        locked_d = locked_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (gnt_any) begin
            last_d   = gnt_id;
            locked_d = sel_lock;
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
        end else if (locked_q && !own_req && !own_lock) begin
            // Owner walked away without keeping the lock
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= M1;
            locked_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            last_q   <= last_d;
            locked_q <= locked_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.mem_we    = gnt_any && sel_we;
    assign bus.mem_addr  = gnt_any ? sel_addr  : addr_q;
    assign bus.mem_wdata = gnt_any ? sel_wdata : wdata_q;

    assign bus.m0_gnt = gnt_any && (gnt_id == M0);
    assign bus.m1_gnt = gnt_any && (gnt_id == M1);

    assign tag_in.valid = gnt_any && !sel_we;
    assign tag_in.owner = gnt_id;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign bus.m0_rvalid = !rst && tag_out.valid && (tag_out.owner == M0);
    assign bus.m1_rvalid = !rst && tag_out.valid && (tag_out.owner == M1);
    assign bus.m0_rdata  = bus.mem_rdata;
    assign bus.m1_rdata  = bus.mem_rdata;

endmodule
